store_capture_fifo: RTL and testbench
=====================================

STORE_CAPTURE_FIFO -- requirements
Module: store_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8: bus width of adr and writedata.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-003 Parameter MATCH_ADR, default 255: store address checked by the match detector.
REQ-004 Parameter MATCH_DATA, default 210: store data checked by the match detector.
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock, shared with the processor and external memory.
- reset  in  1  asynchronous active-high reset.
- memwrite  in  1  processor store strobe, the same net that drives external memory.
- adr  in  WIDTH  store byte address.
- writedata  in  WIDTH  store byte data.
- out_valid  out  1  FIFO head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_adr  out  WIDTH  head entry address.
- out_data  out  WIDTH  head entry data.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a store was dropped.
- match  out  1  sticky flag: a store hit MATCH_ADR/MATCH_DATA.

Function
REQ-007 A push SHALL occur on a rising clk edge when memwrite=1 and the FIFO is not full, capturing {adr, writedata}.
REQ-008 A pop SHALL occur on a rising clk edge when out_valid=1 and out_ready=1.
REQ-009 The FIFO SHALL be first-word-fall-through: out_adr/out_data SHALL always present the oldest entry, and out_valid SHALL equal (count != 0).
REQ-010 Push-to-visible latency SHALL be one cycle: a store captured at edge N SHALL raise out_valid after edge N on an empty FIFO.
REQ-011 When the FIFO is full, a simultaneous push and pop in the same cycle SHALL both be accepted and count SHALL stay at DEPTH.
REQ-012 When the FIFO is full without a pop, a store SHALL be dropped and overflow SHALL set after that edge; overflow SHALL stay set until reset.
REQ-013 When the FIFO is empty, a simultaneous push and pop is impossible because out_valid=0; the push SHALL proceed normally.
REQ-014 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL increment on push-only, decrement on pop-only, and hold otherwise.
REQ-015 When out_valid=0, out_ready SHALL be ignored, and count SHALL never underflow.
REQ-016 When out_valid=0, out_adr/out_data SHALL be don't-care, and the bench SHALL NOT check them.
REQ-017 memwrite sampled as X/Z SHALL NOT be required to be handled; the upstream guarantees a known level after reset.

Reset
REQ-018 Asserting reset SHALL immediately, without a clock, clear the pointers, count=0, out_valid=0, overflow=0 and match=0.
REQ-019 Asserting reset mid-operation SHALL discard all stored entries.
REQ-020 Storage array contents SHALL NOT be required to reset.
REQ-021 The first push after reset deassertion SHALL be accepted at the first rising edge with memwrite=1.

Configuration
REQ-022 With macro STORE_MATCH_EN defined, match SHALL set on the edge where memwrite=1, adr==MATCH_ADR and writedata==MATCH_DATA.
REQ-023 With STORE_MATCH_EN defined, match SHALL set regardless of FIFO full state and SHALL stay set until reset.
REQ-024 Without STORE_MATCH_EN, match SHALL be tied to 0 and no comparator logic SHALL be synthesized.

Verification
REQ-025 Single store: reset, then memwrite=1 for one cycle with adr=255, writedata=210 -> next cycle out_valid=1, out_adr=255, out_data=210, count=1, match=1 (macro defined) or 0 (undefined).
REQ-026 Fill/drain: out_ready=0, push data 1..8 to addresses 0..7 -> count=8; then out_ready=1 -> data pops in order 1..8, count returns to 0, out_valid=0.
REQ-027 Overflow: with 8 entries held, push adr=9, data=99 -> count stays 8, overflow=1, 99 never appears at the head.
REQ-028 Full simultaneous: count=8, out_ready=1, push adr=20, data=20 -> count=8, and the entry 20 emerges after the 8 older entries.
REQ-029 Wrap: 20 interleaved push/pop pairs with out_ready=1 -> data order preserved across pointer wrap, overflow=0.
REQ-030 Async reset: count=5, assert reset between clock edges -> count=0, out_valid=0, overflow=0 before the next rising edge.

Source files
------------

// File: rtl/store_capture_fifo.sv
// Snoops processor stores (memwrite/adr/writedata) into a first-word-fall-through FIFO,
// with a sticky overflow flag. Optional store match detector enabled by macro STORE_MATCH_EN.
module store_capture_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int MATCH_ADR  = 255,
  parameter int MATCH_DATA = 210
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [WIDTH-1:0]         adr,
  input  logic [WIDTH-1:0]         writedata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_adr,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     match
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 full, push, pop, drop;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic [2*WIDTH-1:0]   head;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    full = (count_q == FULL_COUNT);
    pop  = (count_q != '0) && out_ready;
    push = memwrite && (!full || pop);
    drop = memwrite && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {adr, writedata};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_adr   = head[2*WIDTH-1:WIDTH];
  assign out_data  = head[WIDTH-1:0];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef STORE_MATCH_EN
  localparam logic [WIDTH-1:0] MATCH_ADR_W  = WIDTH'(MATCH_ADR);
  localparam logic [WIDTH-1:0] MATCH_DATA_W = WIDTH'(MATCH_DATA);

  logic match_q, match_d;

  // Independent of FIFO state: a dropped store still counts as a hit.
  always_comb begin
    match_d = match_q;
    if (memwrite && (adr == MATCH_ADR_W) && (writedata == MATCH_DATA_W)) match_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign match = match_q;
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_store_capture_fifo.sv
// Directed self-checking bench for store_capture_fifo (DEPTH=8, WIDTH=8).
module tb_store_capture_fifo;

  logic       clk;
  logic       reset;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_adr;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       overflow;
  logic       match;

  int checks = 0;
  int failures = 0;

`ifdef STORE_MATCH_EN
  localparam logic MATCH_EXP = 1'b1;
`else
  localparam logic MATCH_EXP = 1'b0;
`endif

  store_capture_fifo #(
    .WIDTH(8), .DEPTH(8), .MATCH_ADR(255), .MATCH_DATA(210)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .out_valid(out_valid), .out_ready(out_ready), .out_adr(out_adr), .out_data(out_data),
    .count(count), .overflow(overflow), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; adr = '0; writedata = '0; out_ready = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_match", match, 0);
    tick();
    reset = 1'b0;

    // Single store of the match pattern
    memwrite = 1'b1; adr = 8'd255; writedata = 8'd210;
    tick();
    memwrite = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_adr", out_adr, 255);
    check("single_data", out_data, 210);
    check("single_count", count, 1);
    check("single_match", match, MATCH_EXP);
    $display("txn single: adr=%0d data=%0d count=%0d match=%0d", out_adr, out_data, count, match);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", out_valid, 0);

    // Fill with data 1..8 at addresses 0..7
    for (int i = 0; i < 8; i++) begin
      memwrite = 1'b1; adr = 8'(i); writedata = 8'(i + 1);
      tick();
    end
    memwrite = 1'b0;
    check("fill_count", count, 8);
    check("fill_head_adr", out_adr, 0);
    check("fill_head_data", out_data, 1);
    check("fill_overflow", overflow, 0);
    $display("txn fill: count=%0d head=%0d", count, out_data);

    // Overflow: store while full with no pop is dropped
    memwrite = 1'b1; adr = 8'd9; writedata = 8'd99;
    tick();
    memwrite = 1'b0;
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head_data", out_data, 1);
    $display("txn overflow: count=%0d overflow=%0d", count, overflow);

    // Full simultaneous push+pop: 1 leaves, 20 enters
    out_ready = 1'b1; memwrite = 1'b1; adr = 8'd20; writedata = 8'd20;
    tick();
    memwrite = 1'b0;
    check("simul_count", count, 8);
    $display("txn simul: count=%0d", count);

    // Drain: 2..8 at addresses 1..7, then 20; 99 must never appear
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, (k < 7) ? k + 2 : 20);
      check("drain_adr", out_adr, (k < 7) ? k + 1 : 20);
      $display("txn drain %0d: adr=%0d data=%0d", k, out_adr, out_data);
      tick();
    end
    check("drain_count", count, 0);
    check("drain_valid_end", out_valid, 0);
    tick();
    check("underflow_count", count, 0);
    check("sticky_overflow", overflow, 1);
    check("sticky_match", match, MATCH_EXP);
    out_ready = 1'b0;

    // Async reset with 5 entries held, asserted between edges
    for (int i = 0; i < 5; i++) begin
      memwrite = 1'b1; adr = 8'(40 + i); writedata = 8'(60 + i);
      tick();
    end
    memwrite = 1'b0;
    check("pre_areset_count", count, 5);
    #3 reset = 1'b1;
    #1;
    check("areset_count", count, 0);
    check("areset_valid", out_valid, 0);
    check("areset_overflow", overflow, 0);
    check("areset_match", match, 0);
    $display("txn async_reset: count=%0d valid=%0d overflow=%0d", count, out_valid, overflow);
    #1 reset = 1'b0;

    // Wrap: 20 push/pop pairs; first push after reset must land immediately
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      memwrite = 1'b1; adr = 8'(100 + i); writedata = 8'(50 + i);
      tick();
      memwrite = 1'b0;
      check("wrap_count1", count, 1);
      check("wrap_adr", out_adr, 100 + i);
      check("wrap_data", out_data, 50 + i);
      $display("txn wrap %0d: adr=%0d data=%0d", i, out_adr, out_data);
      tick();
      check("wrap_count0", count, 0);
    end
    check("wrap_overflow", overflow, 0);
    check("wrap_match", match, 0);

    // Match pattern offered while full is dropped but still detected
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      memwrite = 1'b1; adr = 8'(i); writedata = 8'(i);
      tick();
    end
    memwrite = 1'b1; adr = 8'd255; writedata = 8'd210;
    tick();
    memwrite = 1'b0;
    check("full_match_count", count, 8);
    check("full_match_overflow", overflow, 1);
    check("full_match_flag", match, MATCH_EXP);
    check("full_match_head", out_data, 0);
    $display("txn full_match: count=%0d overflow=%0d match=%0d", count, overflow, match);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
